// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared widths and constants for the pipelined CPU datapath.
//   DATA_W      : datapath / memory word width
//   REG_ADDR_W  : register-file address width
//   WORD_SHIFT  : byte-address to word-index shift (4-byte words)
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WORD_SHIFT = 2;

endpackage : cpu_pkg

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
// Word-organised SIZE x DATA_W data memory with a clocked write port and a
// combinational, gated read port. Byte address bits below the word boundary
// are ignored; addresses whose word index is >= SIZE are out of range: stores
// there are dropped and loads return zero.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset (blocks stores while held)
//   wr_en    in   store enable
//   rd_en    in   load enable
//   addr     in   byte address
//   wr_data  in   store data
//   rd_data  out  load data (zero when rd_en=0 or out of range)
//
// Optional build macro:
//   DMEM_RESET_CLEAR_EN  when defined, reset asynchronously clears every word.
// ----------------------------------------------------------------------------
module data_memory
    import cpu_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned IDX_W = $clog2(SIZE);

    logic [DATA_W-1:0] mem_q [SIZE];

    logic [DATA_W-1:0] word_addr;
    logic [IDX_W-1:0]  word_idx;
    logic              in_range;
    logic              wr_commit;

    // Range check uses the full shifted address so that indices >= SIZE
    // never alias onto low words via truncation.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a value on all paths
        // (defaults first), otherwise synthesis infers a latch.
        word_addr = addr >> WORD_SHIFT;
        word_idx  = word_addr[IDX_W-1:0];
        in_range  = (word_addr < DATA_W'(SIZE));
        wr_commit = wr_en && in_range && !reset;
        rd_data   = '0;
        // Read returns the stored word before any same-cycle write commits.
        if (rd_en && in_range) begin
            rd_data = mem_q[word_idx];
        end
    end

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_commit) begin
            mem_q[word_idx] <= wr_data;
        end
    end
`else
    // NOTE: the memory array has no reset so it maps onto RAM macros; its
    // contents are undefined until written.
    always_ff @(posedge clock) begin
        if (wr_commit) begin
            mem_q[word_idx] <= wr_data;
        end
    end
`endif

endmodule : data_memory

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// MEM stage of the 5-stage pipeline fused with the MEM/WB register.
// Resolves the branch decision, performs load/store on the data memory and
// registers the write-back payload.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   MemToReg_in/RegWrite_in, RegisterRd_in, ALU_Result_in   WB payload in
//   MemWrite, MemRead, WriteData                            memory access
//   Branch, Is_Zero, PC_Branch_in                           branch resolve
//   PCSrc, PC_Branch_out     combinational, to IF stage
//   MemToReg_out, RegWrite_out, ReadData_out, ALU_Result_out,
//   RegisterRd_out           MEM/WB register outputs (cleared by reset)
//
// Optional build macro:
//   DMEM_RESET_CLEAR_EN  reset also clears data memory (see data_memory).
// ----------------------------------------------------------------------------
module mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  MemToReg_in,
    input  logic                  RegWrite_in,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic                  Branch,
    input  logic                  Is_Zero,
    input  logic [DATA_W-1:0]     ALU_Result_in,
    input  logic [DATA_W-1:0]     WriteData,
    input  logic [REG_ADDR_W-1:0] RegisterRd_in,
    input  logic [DATA_W-1:0]     PC_Branch_in,
    output logic                  PCSrc,
    output logic [DATA_W-1:0]     PC_Branch_out,
    output logic                  MemToReg_out,
    output logic                  RegWrite_out,
    output logic [DATA_W-1:0]     ReadData_out,
    output logic [DATA_W-1:0]     ALU_Result_out,
    output logic [REG_ADDR_W-1:0] RegisterRd_out
);

    logic [DATA_W-1:0] load_data;

    logic                  mem_to_reg_d, mem_to_reg_q;
    logic                  reg_write_d,  reg_write_q;
    logic [DATA_W-1:0]     read_data_d,  read_data_q;
    logic [DATA_W-1:0]     alu_result_d, alu_result_q;
    logic [REG_ADDR_W-1:0] reg_rd_d,     reg_rd_q;

    data_memory #(
        .SIZE    (SIZE)
    ) u_dmem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (MemWrite),
        .rd_en   (MemRead),
        .addr    (ALU_Result_in),
        .wr_data (WriteData),
        .rd_data (load_data)
    );

    // Branch resolution is purely combinational and ignores reset.
    assign PCSrc         = Branch & Is_Zero;
    assign PC_Branch_out = PC_Branch_in;

    always_comb begin
        mem_to_reg_d = MemToReg_in;
        reg_write_d  = RegWrite_in;
        read_data_d  = load_data;
        alu_result_d = ALU_Result_in;
        reg_rd_d     = RegisterRd_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from before the edge, independent of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            reg_rd_q     <= '0;
        end else begin
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            reg_rd_q     <= reg_rd_d;
        end
    end

    assign MemToReg_out   = mem_to_reg_q;
    assign RegWrite_out   = reg_write_q;
    assign ReadData_out   = read_data_q;
    assign ALU_Result_out = alu_result_q;
    assign RegisterRd_out = reg_rd_q;

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
// Scoreboard bench for mem_stage: each stimulus cycle pushes its expected
// MEM/WB and branch outputs; a monitor pops and compares after every edge.
// Build with DMEM_RESET_CLEAR_EN to expect memory clearing on reset.
// ----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clock;
    logic        reset;
    logic        MemToReg_in, RegWrite_in, MemWrite, MemRead, Branch, Is_Zero;
    logic [31:0] ALU_Result_in, WriteData, PC_Branch_in;
    logic [4:0]  RegisterRd_in;
    logic        PCSrc;
    logic [31:0] PC_Branch_out;
    logic        MemToReg_out, RegWrite_out;
    logic [31:0] ReadData_out, ALU_Result_out;
    logic [4:0]  RegisterRd_out;

    typedef struct {
        string       name;
        logic        mem_to_reg;
        logic        reg_write;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  reg_rd;
        logic        pcsrc;
        logic [31:0] pc_branch;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mem_stage #(.SIZE(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .MemToReg_in    (MemToReg_in),
        .RegWrite_in    (RegWrite_in),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .Branch         (Branch),
        .Is_Zero        (Is_Zero),
        .ALU_Result_in  (ALU_Result_in),
        .WriteData      (WriteData),
        .RegisterRd_in  (RegisterRd_in),
        .PC_Branch_in   (PC_Branch_in),
        .PCSrc          (PCSrc),
        .PC_Branch_out  (PC_Branch_out),
        .MemToReg_out   (MemToReg_out),
        .RegWrite_out   (RegWrite_out),
        .ReadData_out   (ReadData_out),
        .ALU_Result_out (ALU_Result_out),
        .RegisterRd_out (RegisterRd_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the
    // outputs must show just after the following rising edge.
    task automatic step(input string name,
                        input logic mtr, input logic rw, input logic mw, input logic mr,
                        input logic br, input logic z,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] pcb,
                        input logic [31:0] exp_data, input logic exp_pcsrc);
        exp_t e;
        @(negedge clock);
        MemToReg_in = mtr; RegWrite_in = rw; MemWrite = mw; MemRead = mr;
        Branch = br; Is_Zero = z; ALU_Result_in = alu; WriteData = wd;
        RegisterRd_in = rd; PC_Branch_in = pcb;
        e.name = name; e.mem_to_reg = mtr; e.reg_write = rw; e.read_data = exp_data;
        e.alu_result = alu; e.reg_rd = rd; e.pcsrc = exp_pcsrc; e.pc_branch = pcb;
        sb.push_back(e);
    endtask

    task automatic store(input string name, input logic [31:0] a, input logic [31:0] d);
        step(name, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, d, 5'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic load(input string name, input logic [31:0] a, input logic [31:0] exp_d);
        step(name, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a, 32'h0, 5'h3, 32'h0, exp_d, 1'b0);
    endtask

    task automatic check_mewb_zero(input string tag);
        check({tag, ".mem_to_reg"}, {31'h0, MemToReg_out}, 32'h0);
        check({tag, ".reg_write"},  {31'h0, RegWrite_out}, 32'h0);
        check({tag, ".read_data"},  ReadData_out, 32'h0);
        check({tag, ".alu_result"}, ALU_Result_out, 32'h0);
        check({tag, ".reg_rd"},     {27'h0, RegisterRd_out}, 32'h0);
    endtask

    // Monitor: compare the oldest expectation after each rising edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".mem_to_reg"}, {31'h0, MemToReg_out}, {31'h0, e.mem_to_reg});
            check({e.name, ".reg_write"},  {31'h0, RegWrite_out}, {31'h0, e.reg_write});
            check({e.name, ".read_data"},  ReadData_out, e.read_data);
            check({e.name, ".alu_result"}, ALU_Result_out, e.alu_result);
            check({e.name, ".reg_rd"},     {27'h0, RegisterRd_out}, {27'h0, e.reg_rd});
            check({e.name, ".pcsrc"},      {31'h0, PCSrc}, {31'h0, e.pcsrc});
            check({e.name, ".pc_branch"},  PC_Branch_out, e.pc_branch);
        end
    end

    task automatic drain(input string tag);
        int budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        #2;
        check({tag, ".drain_remaining"}, sb.size(), 32'h0);
    endtask

    initial begin
        logic [31:0] exp_after_reset;
        reset = 1'b0;
        MemToReg_in = 1'b0; RegWrite_in = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        Branch = 1'b0; Is_Zero = 1'b0; ALU_Result_in = '0; WriteData = '0;
        RegisterRd_in = '0; PC_Branch_in = '0;

        // Reset state, asserted before the first edge.
        #1 reset = 1'b1;
        #1 check_mewb_zero("reset_init");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Stores, then loads one cycle later each.
        store("st0", 32'd0, 32'h0000_FFFF);
        store("st4", 32'd4, 32'h0000_EEEE);
        store("st8", 32'd8, 32'h0000_DDDD);
        load("ld0", 32'd0, 32'h0000_FFFF);
        load("ld4", 32'd4, 32'h0000_EEEE);
        load("ld8", 32'd8, 32'h0000_DDDD);

        // Branch truth table.
        step("br00", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 32'h0000_FFFF, 32'h0, 1'b0);
        step("br10", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'h0, 32'h0000_FFFF, 32'h0, 1'b0);
        step("br01", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'h0, 32'h0000_FFFF, 32'h0, 1'b0);
        step("br11", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 5'h0, 32'h0000_FFFF, 32'h0, 1'b1);

        // Pass-through with MemRead=0: load data forced to zero.
        step("pass", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'h1F, 32'h0, 32'h0, 1'b0);
        // MemRead=0 on a written address still yields zero.
        step("rd_off", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd8, 32'h0, 5'h02, 32'h0, 32'h0, 1'b0);

        // Boundaries: 128 is index 32 (out of range), 6 is word 1, 124 is last word.
        store("st128", 32'd128, 32'h0000_AAAA);
        store("st6",   32'd6,   32'h0000_5555);
        store("st124", 32'd124, 32'h0000_7C7C);
        load("ld128", 32'd128, 32'h0);
        load("ld4b",  32'd4,   32'h0000_5555);
        load("ld124", 32'd124, 32'h0000_7C7C);
        load("ld0b",  32'd0,   32'h0000_FFFF);

        // Same-cycle load/store: load sees the old word, store commits.
        store("st0_1111", 32'd0, 32'h0000_1111);
        step("ldst0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_2222, 5'h4, 32'h0, 32'h0000_1111, 1'b0);
        load("ld0_2222", 32'd0, 32'h0000_2222);
        store("st0_ffff", 32'd0, 32'h0000_FFFF);

        // Make MEM/WB outputs non-zero, then reset mid-cycle.
        step("pre_rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0, 5'h0A, 32'h0, 32'h0000_FFFF, 1'b0);
        drain("pre_rst");
        reset = 1'b1;
        Branch = 1'b1; Is_Zero = 1'b1; PC_Branch_in = 32'h0000_CAFE;
        #1;
        check_mewb_zero("rst_mid");
        check("rst_mid.pcsrc", {31'h0, PCSrc}, 32'h1);
        check("rst_mid.pc_branch", PC_Branch_out, 32'h0000_CAFE);

        // Hold reset across an edge with a store pending: nothing commits.
        MemWrite = 1'b1; MemRead = 1'b1; ALU_Result_in = 32'd0; WriteData = 32'h0000_0BAD;
        MemToReg_in = 1'b1; RegWrite_in = 1'b1; RegisterRd_in = 5'h1F;
        @(posedge clock);
        #1;
        check_mewb_zero("rst_hold");
        @(negedge clock);
        MemWrite = 1'b0;
        reset = 1'b0;

`ifdef DMEM_RESET_CLEAR_EN
        exp_after_reset = 32'h0;
`else
        exp_after_reset = 32'h0000_FFFF;
`endif
        load("ld0_post_rst", 32'd0, exp_after_reset);
        drain("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_mem_stage
